// File: rtl/pcie_ctc_elastic_buf_if.sv
// Symbol stream bundle for the CTC elastic buffer: gearbox-side input stream
// plus consumer-side request/response. slave = the buffer, master = its environment.
interface pcie_ctc_elastic_buf_if #(
  parameter int DATA_W = 8,
  parameter int SB_W   = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_kcntl;
  logic [SB_W-1:0]   in_sb;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_kcntl;
  logic [SB_W-1:0]   out_sb;

  modport master (
    output in_valid, in_data, in_kcntl, in_sb, out_ready,
    input  out_valid, out_data, out_kcntl, out_sb
  );

  modport slave (
    input  in_valid, in_data, in_kcntl, in_sb, out_ready,
    output out_valid, out_data, out_kcntl, out_sb
  );
endinterface

// File: rtl/pcie_ctc_elastic_buf.sv
// Per-lane clock tolerance compensation buffer: DEPTH-entry FIFO that deletes or
// inserts SKP symbols inside COM/SKP ordered sets to keep occupancy centred.
module pcie_ctc_elastic_buf #(
  parameter int                DATA_W      = 8,
  parameter int                SB_W        = 4,
  parameter int                DEPTH       = 16,
  parameter int                HI_THRESH   = 12,
  parameter int                LO_THRESH   = 4,
  parameter int                START_LEVEL = 8,
  parameter logic [DATA_W-1:0] COM_CODE    = 8'hBC,
  parameter logic [DATA_W-1:0] SKP_CODE    = 8'h1C,
  parameter int                MIN_SKP     = 1,
  parameter int                MAX_SKP     = 5,
  parameter int                ERR_CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctc_disable,
  input  logic                         err_clr,
  pcie_ctc_elastic_buf_if.slave        bus,
  output logic                         ctc_skip_added,
  output logic                         ctc_skip_removed,
  output logic                         ctc_over_flow,
  output logic                         ctc_under_flow,
  output logic [$clog2(DEPTH+1)-1:0]   ctc_level,
  output logic [ERR_CNT_W-1:0]         ctc_err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int SYM_W = DATA_W + 1 + SB_W;
  localparam int SKP_W = $clog2(MAX_SKP + 2);

  localparam logic [LW-1:0]    LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_HI    = LW'(HI_THRESH);
  localparam logic [LW-1:0]    LVL_LO    = LW'(LO_THRESH);
  localparam logic [LW-1:0]    LVL_START = LW'(START_LEVEL);
  localparam logic [SKP_W-1:0] SKP_MIN   = SKP_W'(MIN_SKP);
  localparam logic [SKP_W:0]   SKP_MAX   = (SKP_W + 1)'(MAX_SKP);

  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [SKP_W-1:0] skp_inc(input logic [SKP_W-1:0] c);
    return (&c) ? c : c + SKP_W'(1);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] err_sat_add(input logic [ERR_CNT_W-1:0] c,
                                                       input logic [1:0]           n);
    logic [ERR_CNT_W:0] s;
    s = {1'b0, c} + {{(ERR_CNT_W - 1){1'b0}}, n};
    return s[ERR_CNT_W] ? '1 : s[ERR_CNT_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic              vld_p0_q, vld_p0_d;
  logic [DATA_W-1:0] data_p0_q, data_p0_d;
  logic              k_p0_q, k_p0_d;
  logic [SB_W-1:0]   sb_p0_q, sb_p0_d;
  logic [SYM_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              wr_os_q, wr_os_d, rd_os_q, rd_os_d;
  logic [SKP_W-1:0]  wr_skp_q, wr_skp_d, rd_skp_q, rd_skp_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_kcntl_q, out_kcntl_d;
  logic [SB_W-1:0]   out_sb_q, out_sb_d;
  logic              added_q, added_d, removed_q, removed_d;
  logic              oflow_q, oflow_d, uflow_q, uflow_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic              s0_com, s0_skp, del, want_wr, wr, oflow;
  logic              serve, ins, pop, uflow, emit, em_k;
  logic [SYM_W-1:0]  head_sym;
  logic [DATA_W-1:0] head_data, em_data;
  logic              head_k, head_skp;
  logic [SB_W-1:0]   head_sb, em_sb;
  logic [SKP_W:0]    rd_skp_sum;

  // Stage p0 -> FIFO write: delete/overflow decisions on the registered input symbol
  assign s0_com  = vld_p0_q && k_p0_q && (data_p0_q == COM_CODE);
  assign s0_skp  = vld_p0_q && k_p0_q && (data_p0_q == SKP_CODE);
  assign del     = s0_skp && wr_os_q && (level_q >= LVL_HI) && (wr_skp_q >= SKP_MIN) && !ctc_disable;
  assign want_wr = vld_p0_q && !del;
  assign wr      = want_wr && ((level_q != LVL_FULL) || pop);
  assign oflow   = want_wr && (level_q == LVL_FULL) && !pop;

  // FIFO head -> output register: insert/pop/underflow decisions
  assign head_sym  = mem_q[rd_ptr_q];
  assign head_data = head_sym[SYM_W-1 -: DATA_W];
  assign head_k    = head_sym[SB_W];
  assign head_sb   = head_sym[SB_W-1:0];
  // A SKP already waiting at the head uses up one slot of this ordered set's budget,
  // so insertion stops early enough that the buffered SKP still fits under MAX_SKP.
  assign head_skp   = (level_q != '0) && head_k && (head_data == SKP_CODE);
  assign rd_skp_sum = {1'b0, rd_skp_q} + {{SKP_W{1'b0}}, head_skp};

  assign serve = (state_q == ST_RUN) && bus.out_ready;
  assign ins   = serve && rd_os_q && (level_q <= LVL_LO) && (rd_skp_sum < SKP_MAX) && !ctc_disable;
  assign pop   = serve && !ins && (level_q != '0);
  assign uflow = serve && !ins && (level_q == '0);
  assign emit  = ins || pop;

  assign em_data = ins ? SKP_CODE : head_data;
  assign em_k    = ins ? 1'b1 : head_k;
  assign em_sb   = ins ? out_sb_q : head_sb;

  always_comb begin
    vld_p0_d    = bus.in_valid;
    data_p0_d   = bus.in_data;
    k_p0_d      = bus.in_kcntl;
    sb_p0_d     = bus.in_sb;
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    wr_os_d     = wr_os_q;
    wr_skp_d    = wr_skp_q;
    rd_os_d     = rd_os_q;
    rd_skp_d    = rd_skp_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_kcntl_d = out_kcntl_q;
    out_sb_d    = out_sb_q;
    added_d     = ins;
    removed_d   = del;
    oflow_d     = oflow;
    uflow_d     = uflow;

    if (wr)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (vld_p0_q) begin
      if (s0_com) begin
        wr_os_d  = 1'b1;
        wr_skp_d = '0;
      end else if (s0_skp) begin
        if (wr) wr_skp_d = skp_inc(wr_skp_q);
      end else begin
        wr_os_d = 1'b0;
      end
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = em_data;
      out_kcntl_d = em_k;
      out_sb_d    = em_sb;
      if (em_k && (em_data == COM_CODE)) begin
        rd_os_d  = 1'b1;
        rd_skp_d = '0;
      end else if (em_k && (em_data == SKP_CODE)) begin
        rd_skp_d = skp_inc(rd_skp_q);
      end else begin
        rd_os_d = 1'b0;
      end
    end

    err_d = err_clr ? '0 : err_sat_add(err_q, {1'b0, oflow} + {1'b0, uflow});

    case (state_q)
      ST_PRIME: if (level_q >= LVL_START) state_d = ST_RUN;
      ST_RUN:   if (uflow) state_d = ST_PRIME;
      default:  state_d = ST_PRIME;
    endcase
  end

  // Stage p0 capture of the input symbol payload
  always_ff @(posedge clk) begin
    data_p0_q <= data_p0_d;
    k_p0_q    <= k_p0_d;
    sb_p0_q   <= sb_p0_d;
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {data_p0_q, k_p0_q, sb_p0_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PRIME;
      vld_p0_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wr_os_q     <= 1'b0;
      wr_skp_q    <= '0;
      rd_os_q     <= 1'b0;
      rd_skp_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_kcntl_q <= 1'b0;
      out_sb_q    <= '0;
      added_q     <= 1'b0;
      removed_q   <= 1'b0;
      oflow_q     <= 1'b0;
      uflow_q     <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      vld_p0_q    <= vld_p0_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wr_os_q     <= wr_os_d;
      wr_skp_q    <= wr_skp_d;
      rd_os_q     <= rd_os_d;
      rd_skp_q    <= rd_skp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_kcntl_q <= out_kcntl_d;
      out_sb_q    <= out_sb_d;
      added_q     <= added_d;
      removed_q   <= removed_d;
      oflow_q     <= oflow_d;
      uflow_q     <= uflow_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_kcntl     = out_kcntl_q;
  assign bus.out_sb        = out_sb_q;
  assign ctc_skip_added    = added_q;
  assign ctc_skip_removed  = removed_q;
  assign ctc_over_flow     = oflow_q;
  assign ctc_under_flow    = uflow_q;
  assign ctc_level         = level_q;
  assign ctc_err_count     = err_q;

endmodule

// File: tb/tb_pcie_ctc_elastic_buf.sv
// Bench for pcie_ctc_elastic_buf: ramp-up vector table plus ordered-set, overflow,
// underflow and ctc_disable sequences, with a symbol scoreboard on the output.
module tb_pcie_ctc_elastic_buf;
  localparam int LW = 5;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  logic clk = 1'b0;
  logic rst, ctc_disable, err_clr;
  logic added, removed, oflow, uflow;
  logic [LW-1:0] level;
  logic [7:0] err_cnt;

  pcie_ctc_elastic_buf_if #(.DATA_W(8), .SB_W(4)) bus ();

  pcie_ctc_elastic_buf #(.DATA_W(8), .SB_W(4), .DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .ctc_disable      (ctc_disable),
    .err_clr          (err_clr),
    .bus              (bus),
    .ctc_skip_added   (added),
    .ctc_skip_removed (removed),
    .ctc_over_flow    (oflow),
    .ctc_under_flow   (uflow),
    .ctc_level        (level),
    .ctc_err_count    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_ready;
    logic [LW-1:0] exp_level;
    logic          exp_out_valid;
  } vec_t;

  vec_t        ramp [23];
  logic [12:0] exp_q [$];
  int n_tests, n_fail, n_out, n_added, n_removed, n_oflow, n_uflow, cur_run, max_run;
  logic [3:0] last_sb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [12:0] e;
    if (added === 1'b1) n_added++;
    if (removed === 1'b1) n_removed++;
    if (oflow === 1'b1) n_oflow++;
    if (uflow === 1'b1) begin
      n_uflow++;
      check("uflow_out_valid", bus.out_valid, 0);
    end
    if (added === 1'b1) check("added_out_valid", bus.out_valid, 1);
    if (bus.out_valid === 1'b1) begin
      n_out++;
      if (added === 1'b1) begin
        e = {SKP, 1'b1, last_sb};
        check("inserted_sym", {bus.out_data, bus.out_kcntl, bus.out_sb}, e);
      end else if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: got %0h, expected no symbol",
                 {bus.out_data, bus.out_kcntl, bus.out_sb});
      end else begin
        e = exp_q.pop_front();
        check("out_sym", {bus.out_data, bus.out_kcntl, bus.out_sb}, e);
      end
      last_sb = bus.out_sb;
      if (bus.out_kcntl && bus.out_data == COM) cur_run = 0;
      else if (bus.out_kcntl && bus.out_data == SKP) begin
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else cur_run = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic drive_sym(input logic [7:0] d, input logic k, input logic [3:0] sb, input logic keep);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_kcntl = k;
    bus.in_sb    = sb;
    if (keep) exp_q.push_back({d, k, sb});
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    check("rst_level", level, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sym", {bus.out_data, bus.out_kcntl, bus.out_sb}, 0);
    check("rst_flags", {added, removed, oflow, uflow}, 0);
    check("rst_err", err_cnt, 0);
    step();
    rst = 1'b0;
    exp_q.delete();
    cur_run = 0;
  endtask

  task automatic wait_uflow(input int base, input int budget);
    int c;
    c = 0;
    while (n_uflow == base && c < budget) begin
      step();
      c++;
    end
  endtask

  initial begin
    int a0, r0, o0, u0, out0;
    rst = 1'b1; ctc_disable = 1'b0; err_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_kcntl = 1'b0; bus.in_sb = '0; bus.out_ready = 1'b0;
    n_tests = 0; n_fail = 0; n_out = 0; n_added = 0; n_removed = 0; n_oflow = 0; n_uflow = 0;
    cur_run = 0; max_run = 0; last_sb = '0;

    for (int r = 0; r < 23; r++) begin
      ramp[r].in_valid      = (r < 12);
      ramp[r].in_data       = 8'h40 + 8'(r);
      ramp[r].out_ready     = (r < 22);
      ramp[r].exp_level     = (r <= 9) ? LW'(r) : (r <= 12) ? LW'(9) : (r <= 21) ? LW'(21 - r) : '0;
      ramp[r].exp_out_valid = (r >= 10 && r <= 21);
    end

    apply_reset();

    // ramp-up table
    a0 = n_added; r0 = n_removed; o0 = n_oflow; u0 = n_uflow; out0 = n_out;
    for (int r = 0; r < 23; r++) begin
      bus.in_valid  = ramp[r].in_valid;
      bus.in_data   = ramp[r].in_data;
      bus.in_kcntl  = 1'b0;
      bus.in_sb     = ramp[r].in_data[3:0];
      bus.out_ready = ramp[r].out_ready;
      if (ramp[r].in_valid) exp_q.push_back({ramp[r].in_data, 1'b0, ramp[r].in_data[3:0]});
      step();
      check($sformatf("ramp_level[%0d]", r), level, ramp[r].exp_level);
      check($sformatf("ramp_out_valid[%0d]", r), bus.out_valid, ramp[r].exp_out_valid);
    end
    bus.in_valid = 1'b0;
    check("ramp_pulses", (n_added - a0) + (n_removed - r0) + (n_oflow - o0) + (n_uflow - u0), 0);
    check("ramp_outputs", n_out - out0, 12);
    check("ramp_queue_left", exp_q.size(), 0);

    // fast producer: deletion inside an ordered set
    apply_reset();
    a0 = n_added; r0 = n_removed; o0 = n_oflow; u0 = n_uflow; out0 = n_out;
    for (int i = 0; i < 12; i++) drive_sym(8'h10 + 8'(i), 1'b0, 4'(i), 1'b1);
    drive_sym(COM, 1'b1, 4'hA, 1'b1);
    drive_sym(SKP, 1'b1, 4'hB, 1'b1);
    drive_sym(SKP, 1'b1, 4'hC, 1'b0);
    drive_sym(SKP, 1'b1, 4'hD, 1'b0);
    step(); step();
    check("del_removed", n_removed - r0, 2);
    check("del_level", level, 14);
    check("del_no_oflow", n_oflow - o0, 0);

    // overflow
    drive_sym(8'h21, 1'b0, 4'h1, 1'b1);
    drive_sym(8'h22, 1'b0, 4'h2, 1'b1);
    for (int i = 0; i < 3; i++) drive_sym(8'h30 + 8'(i), 1'b0, 4'h3, 1'b0);
    step(); step();
    check("ovf_pulses", n_oflow - o0, 3);
    check("ovf_err", err_cnt, 3);
    check("ovf_level", level, 16);
    check("ovf_removed", n_removed - r0, 2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr", err_cnt, 0);

    // drain: SKP insertion at low level, MAX_SKP limit, then underflow
    bus.out_ready = 1'b1;
    wait_uflow(u0, 60);
    check("ins_added", n_added - a0, 4);
    check("ins_max_run", max_run, 5);
    check("drain_outputs", n_out - out0, 20);
    check("uflow_pulses", n_uflow - u0, 1);
    check("uflow_err", err_cnt, 1);
    check("drain_queue_left", exp_q.size(), 0);
    check("drain_level", level, 0);

    // re-prime: no service below START_LEVEL, then mid-stream reset
    out0 = n_out; u0 = n_uflow;
    for (int i = 0; i < 7; i++) drive_sym(8'h50 + 8'(i), 1'b0, 4'(i), 1'b1);
    step(); step(); step();
    check("prime_no_output", n_out - out0, 0);
    check("prime_no_uflow", n_uflow - u0, 0);
    check("prime_level", level, 7);
    apply_reset();

    // ctc_disable: plain FIFO through the same ordered set
    ctc_disable = 1'b1;
    apply_reset();
    a0 = n_added; r0 = n_removed; o0 = n_oflow; u0 = n_uflow; out0 = n_out;
    for (int i = 0; i < 12; i++) drive_sym(8'h60 + 8'(i), 1'b0, 4'(i), 1'b1);
    drive_sym(COM, 1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 3; i++) drive_sym(SKP, 1'b1, 4'(6 + i), 1'b1);
    step(); step();
    check("dis_removed", n_removed - r0, 0);
    check("dis_level", level, 16);
    bus.out_ready = 1'b1;
    wait_uflow(u0, 60);
    check("dis_added", n_added - a0, 0);
    check("dis_outputs", n_out - out0, 16);
    check("dis_oflow", n_oflow - o0, 0);
    check("dis_uflow", n_uflow - u0, 1);
    check("dis_queue_left", exp_q.size(), 0);
    check("max_skp_run_final", max_run, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
